// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU pipeline slice.
//  - CTRL_W and the bit positions of each field in the packed control bus.
//    The decoder, forwarding unit and EX/MEM stage use the same positions.
//  - upd_e: what the ID/EX register does on a given clock edge.
package cpu_pkg;

    localparam int CTRL_W    = 8;

    // Packed control bus field positions
    localparam int REG_WRITE = 0;
    localparam int MEM_READ  = 1;
    localparam int MEM_WRITE = 2;
    localparam int MEM_2_REG = 3;
    localparam int ALU_SRC   = 4;
    localparam int ALU_OP_LO = 5;
    localparam int ALU_OP_HI = 7;

    // Register update action for a pipeline stage on one edge
    typedef enum logic [1:0] {
        UPD_HOLD   = 2'd0,
        UPD_BUBBLE = 2'd1,
        UPD_LOAD   = 2'd2
    } upd_e;

endpackage : cpu_pkg

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter.
//  clk     in   1      clock, rising edge
//  arst_n  in   1      asynchronous active-low reset, clears cnt
//  inc     in   1      count one event on this edge
//  cnt     out  CNT_W  current count; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// branch flush and saturating stall/flush performance counters.
//  clk, arst_n          clock (rising) and async active-low reset
//  enable               global advance; 0 freezes every register
//  flush                squash the ID instruction (EX redirect)
//  valid_id, uses_rs2_id, rs1_id, rs2_id, rd_id, ctrl_id,
//  rdata1_id, rdata2_id, imm_id, pc_id     decoded instruction from ID
//  valid_ex, rs1_ex, rs2_ex, rd_ex, ctrl_ex,
//  rdata1_ex, rdata2_ex, imm_ex, pc_ex     registered instruction into EX
//  stall_if_id          combinational: hold PC and IF/ID this cycle
//  stall_cnt, flush_cnt saturating event counters
//
// No valid/ready handshake here: valid_id/valid_ex only qualify the payload,
// and back-pressure to IF/ID is the single combinational stall_if_id.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = cpu_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              flush,
    input  logic              valid_id,
    input  logic              uses_rs2_id,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic [4:0]        rd_id,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic [DATA_W-1:0] rdata1_id,
    input  logic [DATA_W-1:0] rdata2_id,
    input  logic [DATA_W-1:0] imm_id,
    input  logic [DATA_W-1:0] pc_id,
    output logic              valid_ex,
    output logic [4:0]        rs1_ex,
    output logic [4:0]        rs2_ex,
    output logic [4:0]        rd_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [DATA_W-1:0] rdata1_ex,
    output logic [DATA_W-1:0] rdata2_ex,
    output logic [DATA_W-1:0] imm_ex,
    output logic [DATA_W-1:0] pc_ex,
    output logic              stall_if_id,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              valid_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [4:0]        rd_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata2_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] pc_q;

    logic hazard;
    logic rs1_match;
    logic rs2_match;
    upd_e upd;

    // A load in EX whose destination is read by the ID instruction.
    // x0 is never a real dependency. A flushed ID instruction is wrong-path,
    // so it must not stall the front end.
    assign rs1_match = (rd_q == rs1_id);
    assign rs2_match = uses_rs2_id && (rd_q == rs2_id);
    assign hazard    = valid_q && ctrl_q[MEM_READ] && (rd_q != 5'd0) &&
                       valid_id && !flush && (rs1_match || rs2_match);

    assign stall_if_id = hazard;

    always_comb begin
        upd = UPD_LOAD;
        if (!enable) begin
            upd = UPD_HOLD;
        end else if (flush || hazard) begin
            upd = UPD_BUBBLE;
        end
    end

    // Bubbles clear control and indices so forwarding/hazard logic never
    // matches against them; data fields keep their old value. A load of an
    // invalid ID slot is treated the same for control and indices.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q  <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            ctrl_q   <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
        end else begin
            case (upd)
                UPD_BUBBLE: begin
                    valid_q <= 1'b0;
                    rs1_q   <= '0;
                    rs2_q   <= '0;
                    rd_q    <= '0;
                    ctrl_q  <= '0;
                end
                UPD_LOAD: begin
                    valid_q  <= valid_id;
                    rs1_q    <= valid_id ? rs1_id  : 5'd0;
                    rs2_q    <= valid_id ? rs2_id  : 5'd0;
                    rd_q     <= valid_id ? rd_id   : 5'd0;
                    ctrl_q   <= valid_id ? ctrl_id : {CTRL_W{1'b0}};
                    rdata1_q <= rdata1_id;
                    rdata2_q <= rdata2_id;
                    imm_q    <= imm_id;
                    pc_q     <= pc_id;
                end
                default: begin
                end
            endcase
        end
    end

    assign valid_ex  = valid_q;
    assign rs1_ex    = rs1_q;
    assign rs2_ex    = rs2_q;
    assign rd_ex     = rd_q;
    assign ctrl_ex   = ctrl_q;
    assign rdata1_ex = rdata1_q;
    assign rdata2_ex = rdata2_q;
    assign imm_ex    = imm_q;
    assign pc_ex     = pc_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (hazard && enable),
        .cnt    (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (flush && enable),
        .cnt    (flush_cnt)
    );

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage. Counters are built 8 bits wide here so that
// saturation is reachable in a short run.
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam int DW = 32;
  localparam int CW = CTRL_W;
  localparam int NW = 8;
  localparam int CNT_MAX = (1 << NW) - 1;
  localparam logic [CW-1:0] C_ADD = 8'h01;  // REG_WRITE
  localparam logic [CW-1:0] C_LW  = 8'h0B;  // REG_WRITE | MEM_READ | MEM_2_REG

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst_n = 1'b1;
  always #5 clk = ~clk;

  logic          enable, flush, valid_id, uses_rs2_id;
  logic [4:0]    rs1_id, rs2_id, rd_id;
  logic [CW-1:0] ctrl_id;
  logic [DW-1:0] rdata1_id, rdata2_id, imm_id, pc_id;
  logic          valid_ex, stall_if_id;
  logic [4:0]    rs1_ex, rs2_ex, rd_ex;
  logic [CW-1:0] ctrl_ex;
  logic [DW-1:0] rdata1_ex, rdata2_ex, imm_ex, pc_ex;
  logic [NW-1:0] stall_cnt, flush_cnt;

  id_ex_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .flush(flush),
    .valid_id(valid_id), .uses_rs2_id(uses_rs2_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .ctrl_id(ctrl_id),
    .rdata1_id(rdata1_id), .rdata2_id(rdata2_id), .imm_id(imm_id), .pc_id(pc_id),
    .valid_ex(valid_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .ctrl_ex(ctrl_ex), .rdata1_ex(rdata1_ex), .rdata2_ex(rdata2_ex),
    .imm_ex(imm_ex), .pc_ex(pc_ex), .stall_if_id(stall_if_id),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // EX slot contents as an instruction record, plus event tallies.
  typedef struct {
    bit v; bit [4:0] rs1, rs2, rd; bit [CW-1:0] c;
    bit [DW-1:0] d1, d2, imm, pc;
  } slot_t;
  slot_t m_ex = '{default: 0};
  int m_scnt = 0;
  int m_fcnt = 0;

  // The ID instruction needs the value a load in EX has not produced yet.
  function automatic bit model_hazard();
    bit reads_it;
    if (!(m_ex.v && m_ex.c[MEM_READ] && m_ex.rd != 0)) return 0;
    if (!valid_id || flush) return 0;
    reads_it = (rs1_id == m_ex.rd) || (uses_rs2_id && rs2_id == m_ex.rd);
    return reads_it;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_ex = '{default: 0};
      m_scnt = 0;
      m_fcnt = 0;
    end else if (enable) begin
      if (flush || model_hazard()) begin
        if (flush) m_fcnt = (m_fcnt < CNT_MAX) ? m_fcnt + 1 : CNT_MAX;
        else       m_scnt = (m_scnt < CNT_MAX) ? m_scnt + 1 : CNT_MAX;
        m_ex.v = 0; m_ex.rs1 = 0; m_ex.rs2 = 0; m_ex.rd = 0; m_ex.c = 0;
      end else begin
        m_ex.v   = valid_id;
        m_ex.rs1 = valid_id ? rs1_id : 5'd0;
        m_ex.rs2 = valid_id ? rs2_id : 5'd0;
        m_ex.rd  = valid_id ? rd_id : 5'd0;
        m_ex.c   = valid_id ? ctrl_id : '0;
        m_ex.d1 = rdata1_id; m_ex.d2 = rdata2_id; m_ex.imm = imm_id; m_ex.pc = pc_id;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid_ex", valid_ex, m_ex.v);
      chk("rs1_ex", rs1_ex, m_ex.rs1);
      chk("rs2_ex", rs2_ex, m_ex.rs2);
      chk("rd_ex", rd_ex, m_ex.rd);
      chk("ctrl_ex", ctrl_ex, m_ex.c);
      chk("rdata1_ex", rdata1_ex, m_ex.d1);
      chk("rdata2_ex", rdata2_ex, m_ex.d2);
      chk("imm_ex", imm_ex, m_ex.imm);
      chk("pc_ex", pc_ex, m_ex.pc);
      chk("stall_if_id", stall_if_id, model_hazard());
      chk("stall_cnt", stall_cnt, m_scnt[NW-1:0]);
      chk("flush_cnt", flush_cnt, m_fcnt[NW-1:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [CW-1:0] c, input logic u2);
    valid_id = v; rs1_id = a; rs2_id = b; rd_id = d; ctrl_id = c; uses_rs2_id = u2;
    rdata1_id = $urandom; rdata2_id = $urandom; imm_id = $urandom; pc_id = $urandom;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 arst_n = 1'b0;
    @(posedge clk);
    #1 arst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    enable = 1'b1; flush = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, '0, 1'b0);
    #2 arst_n = 1'b0;
    #1;
    chk("reset_valid", valid_ex, 1'b0);
    chk("reset_ctrl", ctrl_ex, 8'h00);
    chk("reset_stall_cnt", stall_cnt, 8'h00);
    chk("reset_stall", stall_if_id, 1'b0);
    cmp_en = 1'b1;
    @(posedge clk);
    #1 arst_n = 1'b1;

    // pass-through
    drive(1'b1, 5'd0, 5'd0, 5'd5, C_ADD, 1'b0);
    rdata1_id = 32'hDEADBEEF;
    tick();
    chk("pass_rd", rd_ex, 5'd5);
    chk("pass_rdata1", rdata1_ex, 32'hDEADBEEF);
    chk("pass_valid", valid_ex, 1'b1);
    chk("pass_stall", stall_if_id, 1'b0);

    // load-use: lw x3 then add reading x3
    drive(1'b1, 5'd1, 5'd0, 5'd3, C_LW, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd0, 5'd4, C_ADD, 1'b0);
    #1 chk("lu_stall", stall_if_id, 1'b1);
    tick();
    chk("lu_bubble_ctrl", ctrl_ex, 8'h00);
    chk("lu_bubble_rd", rd_ex, 5'd0);
    chk("lu_bubble_valid", valid_ex, 1'b0);
    chk("lu_stall_cnt", stall_cnt, 8'd1);
    chk("lu_stall_clear", stall_if_id, 1'b0);
    tick();
    chk("lu_add_rd", rd_ex, 5'd4);
    chk("lu_add_valid", valid_ex, 1'b1);

    // no false hazard: load to x0, and rs2 match without uses_rs2
    drive(1'b1, 5'd4, 5'd0, 5'd0, C_LW, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd6, C_ADD, 1'b1);
    #1 chk("nf_x0_stall", stall_if_id, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 5'd3, C_LW, 1'b0);
    tick();
    drive(1'b1, 5'd1, 5'd3, 5'd5, C_ADD, 1'b0);
    #1 chk("nf_rs2_unused", stall_if_id, 1'b0);
    uses_rs2_id = 1'b1;
    #1 chk("rs2_used_stall", stall_if_id, 1'b1);
    uses_rs2_id = 1'b0;
    tick();

    // flush while hazard conditions hold
    drive(1'b1, 5'd0, 5'd0, 5'd3, C_LW, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd0, 5'd4, C_ADD, 1'b0);
    flush = 1'b1;
    #1 chk("fl_stall", stall_if_id, 1'b0);
    tick();
    flush = 1'b0;
    chk("fl_valid", valid_ex, 1'b0);
    chk("fl_ctrl", ctrl_ex, 8'h00);
    chk("fl_flush_cnt", flush_cnt, 8'd1);
    chk("fl_stall_cnt", stall_cnt, 8'd1);

    // freeze for 3 cycles
    drive(1'b1, 5'd0, 5'd0, 5'd7, C_ADD, 1'b0);
    rdata1_id = 32'h12345678;
    tick();
    enable = 1'b0;
    drive(1'b1, 5'd2, 5'd2, 5'd9, C_LW, 1'b1);
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_rd", rd_ex, 5'd7);
      chk("frz_rdata1", rdata1_ex, 32'h12345678);
      chk("frz_stall_cnt", stall_cnt, 8'd1);
      chk("frz_flush_cnt", flush_cnt, 8'd1);
    end
    flush = 1'b0;
    enable = 1'b1;

    // reset mid-stream with valid_id held high
    drive(1'b1, 5'd1, 5'd1, 5'd2, C_ADD, 1'b0);
    @(posedge clk);
    #3 arst_n = 1'b0;
    #1;
    chk("mr_valid", valid_ex, 1'b0);
    chk("mr_rd", rd_ex, 5'd0);
    chk("mr_rdata1", rdata1_ex, 32'h0);
    chk("mr_flush_cnt", flush_cnt, 8'd0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd6, C_ADD, 1'b0);
    rdata1_id = 32'hCAFEF00D;
    tick();
    chk("mr_first_rd", rd_ex, 5'd6);
    chk("mr_first_valid", valid_ex, 1'b1);
    chk("mr_first_rdata1", rdata1_ex, 32'hCAFEF00D);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [CW-1:0] c;
      c = CW'($urandom);
      c[MEM_READ] = $urandom_range(0, 1) != 0;
      drive($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), c, $urandom_range(0, 1) != 0);
      flush = ($urandom_range(0, 9) == 0);
      enable = ($urandom_range(0, 7) != 0);
      tick();
    end
    flush = 1'b0;
    enable = 1'b1;

    // saturation of both counters
    pulse_reset();
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd1, C_LW, 1'b0);
      tick();
      drive(1'b1, 5'd1, 5'd0, 5'd2, C_ADD, 1'b0);
      tick();
    end
    chk("sat_stall_cnt", stall_cnt, 8'hFF);
    chk("sat_flush_zero", flush_cnt, 8'h00);
    flush = 1'b1;
    for (int i = 0; i < CNT_MAX + 5; i++) tick();
    flush = 1'b0;
    chk("sat_flush_cnt", flush_cnt, 8'hFF);
    chk("sat_stall_hold", stall_cnt, 8'hFF);
    tick();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_id_ex_stage
